instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch/prefetch stage between the instruction ROM and the multi-cycle control unit.
- Owns the fetch address and issues single-outstanding ROM reads.
- Buffers returned words with their address in a small FIFO and presents them to the control unit over a valid/ready handshake.
- A redirect from the control unit (taken branch, RJMP) flushes the FIFO and discards any in-flight ROM response.

Parameters:
INSTR_WIDTH, 16, instruction word width
I_ADDR_WIDTH, 10, instruction address width (word addressed)
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, fetch address after reset

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
rom_req  output  1  ROM read request, single-cycle pulse
rom_addr  output  I_ADDR_WIDTH  ROM read address, valid while rom_req=1
rom_valid  input  1  ROM response strobe, >=1 cycle after rom_req
rom_data  input  INSTR_WIDTH  ROM word, valid with rom_valid
instr_valid  output  1  FIFO head valid
instr  output  INSTR_WIDTH  FIFO head instruction
instr_pc  output  I_ADDR_WIDTH  address of FIFO head instruction
instr_ready  input  1  consumer accepts head (pop when instr_valid & instr_ready)
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  I_ADDR_WIDTH  new fetch address

Behaviour:
- Reset: clock and reset are as stated in Ports.
  - fetch_pc=RESET_PC; FIFO empty (count=0, pointers 0); state=IDLE.
  - rom_req=0, rom_addr=0, instr_valid=0, instr=0, instr_pc=0.
- States:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding.
  - DISCARD: one outstanding request whose response must be dropped.
- Response accept: in WAIT, rom_valid=1 and no redirect.
  - Writes {rom_data, pc_of_request} at the tail; count+1 unless a pop occurs in the same cycle.
  - The response is visible on instr_valid the next cycle.
- Issue condition: state is IDLE, or state is WAIT with rom_valid=1; redirect_valid=0; and (count + accept - pop) < DEPTH.
  - On issue: rom_req=1, rom_addr=fetch_pc, fetch_pc<=fetch_pc+1 (wraps modulo 2^I_ADDR_WIDTH, 1023->0), state<=WAIT.
- State transitions:
  - WAIT with rom_valid=1 and no issue -> IDLE.
  - WAIT with rom_valid=0 -> WAIT.
  - rom_valid in IDLE is a protocol error: ignored, no write.
- Back-to-back: with a 1-cycle ROM, a new request may issue in the same cycle as the previous response, giving one instruction per cycle.
- Redirect (highest priority, any state):
  - FIFO cleared and fetch_pc<=redirect_pc.
  - instr_valid forced 0 in the redirect cycle; a concurrent instr_ready is not a pop.
  - No request issues in the redirect cycle.
  - IDLE -> IDLE.
  - WAIT with rom_valid=0 -> DISCARD.
  - WAIT with rom_valid=1 -> response dropped, IDLE.
  - DISCARD -> DISCARD, fetch_pc updated.
- DISCARD: rom_valid=1 -> response dropped, IDLE; no issue that cycle.
- Full: count=DEPTH with no pop means no issue. A pop and an accept in the same cycle keep count unchanged.
- Empty: instr_valid=0. instr/instr_pc hold their last-driven values; consumers must not sample them.
- Reset mid-operation: returns immediately to reset values. A later rom_valid for the pre-reset request arrives in IDLE and is ignored.

Decomposition:
- Shared defines header: fetch state encodings FETCH_IDLE, FETCH_WAIT, FETCH_DISCARD (2 bits).
- Sub-module fetch_fifo (parameterised width INSTR_WIDTH+I_ADDR_WIDTH, DEPTH):
  - ports: push, pop, flush, wdata, rdata, count, empty, full;
  - flush has priority over push/pop.
- FSM, fetch_pc and issue logic live in instr_fetch_unit.

Test Plan:
- Reset, 1-cycle ROM returning word=addr|16'hA000, instr_ready=1:
  - rom_req pulses with addr 0,1,2,... every cycle;
  - instr/instr_pc stream A000/0, A001/1, A002/2 in order, no gaps after the first.
- instr_ready=0, 1-cycle ROM:
  - exactly 4 requests (addr 0..3), then rom_req stays 0 and count=4;
  - raise instr_ready for one cycle -> one pop, then exactly one request for addr 4.
- 3-cycle ROM latency; redirect_valid=1, redirect_pc=10'd100 while WAIT for addr 5:
  - addr-5 response dropped; next request addr 100; first instr_pc=100; FIFO held nothing from before.
- redirect_pc=10'd50 in the same cycle as rom_valid and instr_valid & instr_ready:
  - response dropped, no pop counted; next request addr 50 issues the following cycle.
- redirect_pc=10'd1023, instr_ready=1:
  - fetched instr_pc sequence 1023, 0, 1 (wrap-around).
- Assert reset while WAIT; late rom_valid arrives 2 cycles after reset release:
  - ignored, FIFO empty; first request after reset is addr RESET_PC=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared fetch state encodings and sizing helper
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - ROM, instruction and redirect signals of the fetch stage
interface instr_fetch_unit_if #(
    parameter int INSTR_WIDTH  = 16,
    parameter int I_ADDR_WIDTH = 10
) ();

    logic                    rom_req;
    logic [I_ADDR_WIDTH-1:0] rom_addr;
    logic                    rom_valid;
    logic [INSTR_WIDTH-1:0]  rom_data;

    logic                    instr_valid;
    logic [INSTR_WIDTH-1:0]  instr;
    logic [I_ADDR_WIDTH-1:0] instr_pc;
    logic                    instr_ready;

    logic                    redirect_valid;
    logic [I_ADDR_WIDTH-1:0] redirect_pc;

    modport master (
        output rom_req,
        output rom_addr,
        input  rom_valid,
        input  rom_data,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  rom_req,
        input  rom_addr,
        output rom_valid,
        output rom_data,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// rtl/instr_fetch_unit_fetch_fifo.sv - prefetch FIFO holding {instruction, pc} entries
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding ROM prefetcher with redirect flush
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int INSTR_WIDTH  = 16,
    parameter int I_ADDR_WIDTH = 10,
    parameter int DEPTH        = 4,
    parameter int RESET_PC     = 0
) (
    input logic               clk,
    input logic               reset,
    instr_fetch_unit_if.master bus
);

    localparam int CNT_W = count_width(DEPTH);
    localparam int FW    = INSTR_WIDTH + I_ADDR_WIDTH;

    fetch_state_e            state;
    logic [I_ADDR_WIDTH-1:0] fetch_pc;
    logic [I_ADDR_WIDTH-1:0] req_pc;

    logic [FW-1:0]           fifo_rdata;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;

    logic                    accept;
    logic                    pop;
    logic                    slot_free;
    logic                    room;
    logic                    issue;
    logic [CNT_W:0]          next_count;

    assign accept = (state == FETCH_WAIT) && bus.rom_valid && !bus.redirect_valid;

    assign bus.instr_valid = !fifo_empty && !bus.redirect_valid;
    assign bus.instr       = fifo_rdata[FW-1:I_ADDR_WIDTH];
    assign bus.instr_pc    = fifo_rdata[I_ADDR_WIDTH-1:0];
    assign pop             = bus.instr_valid && bus.instr_ready;

    // Occupancy as it will stand after this edge, so a response landing now
    // and a new request issued now never overrun the FIFO.
    assign next_count = {1'b0, fifo_count} + (CNT_W+1)'(accept) - (CNT_W+1)'(pop);
    assign room       = (!fifo_full || pop) && (next_count < (CNT_W+1)'(DEPTH));

    assign slot_free = (state == FETCH_IDLE) || ((state == FETCH_WAIT) && bus.rom_valid);
    assign issue     = !reset && slot_free && !bus.redirect_valid && room;

    assign bus.rom_req  = issue;
    assign bus.rom_addr = issue ? fetch_pc : '0;

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .wdata ({bus.rom_data, req_pc}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH_IDLE;
            fetch_pc <= I_ADDR_WIDTH'(RESET_PC);
            req_pc   <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc;
            // An outstanding request whose data has not arrived yet must be drained.
            if (state == FETCH_IDLE) begin
                state <= FETCH_IDLE;
            end else begin
                state <= bus.rom_valid ? FETCH_IDLE : FETCH_DISCARD;
            end
        end else if (issue) begin
            state    <= FETCH_WAIT;
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 1'b1;
        end else begin
            case (state)
                FETCH_WAIT: begin
                    if (bus.rom_valid) begin
                        state <= FETCH_IDLE;
                    end
                end
                FETCH_DISCARD: begin
                    if (bus.rom_valid) begin
                        state <= FETCH_IDLE;
                    end
                end
                default: begin
                    state <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench with ROM model and pc/instruction scoreboard
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int RESET_PC = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    instr_fetch_unit_if #(.INSTR_WIDTH(16), .I_ADDR_WIDTH(10)) bus ();

    instr_fetch_unit #(
        .INSTR_WIDTH  (16),
        .I_ADDR_WIDTH (10),
        .DEPTH        (4),
        .RESET_PC     (RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int          lat        = 1;
    bit          stray      = 1'b0;
    logic [15:0] stray_data = 16'h0;

    logic [9:0]  exp_fetch;
    logic [9:0]  exp_q[$];
    logic [9:0]  pop_log[$];
    logic [9:0]  sb_pc;
    int          req_cnt = 0;
    int          pop_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ROM model: word = addr | 16'hA000, delivered lat cycles after the request.
    initial begin : rom_model
        logic       req_n;
        logic [9:0] addr_n;
        logic [9:0] p_addr;
        bit         pend;
        int         due;
        pend = 1'b0;
        due = 0;
        p_addr = '0;
        bus.rom_valid = 1'b0;
        bus.rom_data  = '0;
        forever begin
            @(negedge clk);
            req_n  = bus.rom_req;
            addr_n = bus.rom_addr;
            @(posedge clk);
            #2;
            bus.rom_valid = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (req_n) begin
                    pend   = 1'b1;
                    p_addr = addr_n;
                    due    = lat;
                end
                if (pend) begin
                    due--;
                    if (due == 0) begin
                        bus.rom_valid = 1'b1;
                        bus.rom_data  = 16'hA000 | 16'(p_addr);
                        pend = 1'b0;
                    end
                end
                if (stray) begin
                    bus.rom_valid = 1'b1;
                    bus.rom_data  = stray_data;
                end
            end
        end
    end

    // Request/consume monitor and scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            pop_log.delete();
            exp_fetch = 10'(RESET_PC);
            chk("reset_rom_req", 32'(bus.rom_req), 0);
            chk("reset_instr_valid", 32'(bus.instr_valid), 0);
        end else if (bus.redirect_valid) begin
            exp_q.delete();
            pop_log.delete();
            exp_fetch = bus.redirect_pc;
            chk("redirect_rom_req", 32'(bus.rom_req), 0);
            chk("redirect_instr_valid", 32'(bus.instr_valid), 0);
        end else begin
            if (bus.instr_valid && bus.instr_ready) begin
                pop_cnt++;
                chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    sb_pc = exp_q.pop_front();
                    pop_log.push_back(bus.instr_pc);
                    chk("instr_pc", 32'(bus.instr_pc), 32'(sb_pc));
                    chk("instr", 32'(bus.instr), 32'(16'hA000 | 16'(sb_pc)));
                end
            end
            if (bus.rom_req) begin
                req_cnt++;
                chk("rom_addr", 32'(bus.rom_addr), 32'(exp_fetch));
                exp_q.push_back(exp_fetch);
                exp_fetch = exp_fetch + 10'd1;
            end
        end
    end

    initial begin : stim
        int r0;
        int p0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Reset values
        tick();
        tick();
        chk("rst_rom_req", 32'(bus.rom_req), 0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 0);
        chk("rst_instr", 32'(bus.instr), 0);
        chk("rst_instr_pc", 32'(bus.instr_pc), 0);
        chk("rst_state", 32'(dut.state), 32'(FETCH_IDLE));
        chk("rst_count", 32'(dut.u_fifo.count), 0);

        // 1-cycle ROM streaming, one instruction per cycle
        lat = 1;
        bus.instr_ready = 1'b1;
        do_reset();
        r0 = req_cnt;
        p0 = pop_cnt;
        repeat (12) tick();
        chk("stream_reqs", 32'(req_cnt - r0), 12);
        chk("stream_pops", 32'(pop_cnt - p0), 10);

        // Consumer stalled: FIFO fills after four requests
        bus.instr_ready = 1'b0;
        do_reset();
        r0 = req_cnt;
        p0 = pop_cnt;
        repeat (10) tick();
        chk("full_reqs", 32'(req_cnt - r0), 4);
        chk("full_count", 32'(dut.u_fifo.count), 4);
        chk("full_head_valid", 32'(bus.instr_valid), 1);
        chk("full_head_pc", 32'(bus.instr_pc), 0);
        stray_data = 16'hBEEF;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        chk("stray_idle_count", 32'(dut.u_fifo.count), 4);
        chk("stray_idle_reqs", 32'(req_cnt - r0), 4);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        repeat (4) tick();
        chk("one_pop", 32'(pop_cnt - p0), 1);
        chk("one_refill_req", 32'(req_cnt - r0), 5);
        bus.instr_ready = 1'b1;
        repeat (8) tick();

        // 3-cycle ROM, redirect to 100 while waiting on addr 5
        lat = 3;
        do_reset();
        r0 = req_cnt;
        repeat (16) tick();
        chk("slow_reqs_before_redirect", 32'(req_cnt - r0), 6);
        chk("slow_state_wait", 32'(dut.state), 32'(FETCH_WAIT));
        bus.redirect_pc    = 10'd100;
        bus.redirect_valid = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        chk("slow_state_discard", 32'(dut.state), 32'(FETCH_DISCARD));
        r0 = req_cnt;
        p0 = pop_cnt;
        repeat (10) tick();
        chk("slow_reqs_after_redirect", 32'(req_cnt - r0), 3);
        chk("slow_pops_after_redirect", 32'(pop_cnt - p0), 2);
        chk("slow_first_pc", 32'(pop_log[0]), 100);

        // Redirect to 50 together with rom_valid and a pop attempt
        lat = 1;
        do_reset();
        repeat (5) tick();
        chk("r50_rom_valid", 32'(bus.rom_valid), 1);
        r0 = req_cnt;
        p0 = pop_cnt;
        bus.redirect_pc    = 10'd50;
        bus.redirect_valid = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("r50_next_req", 32'(req_cnt - r0), 1);
        chk("r50_no_pop", 32'(pop_cnt - p0), 0);
        repeat (3) tick();

        // Redirect to 1023: address wraps to 0
        bus.redirect_pc    = 10'd1023;
        bus.redirect_valid = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (6) tick();
        chk("wrap_pops", 32'(pop_log.size()), 4);
        chk("wrap_pc0", 32'(pop_log[0]), 1023);
        chk("wrap_pc1", 32'(pop_log[1]), 0);
        chk("wrap_pc2", 32'(pop_log[2]), 1);

        // Reset while WAIT; late response after release is ignored
        lat = 3;
        bus.instr_ready = 1'b0;
        do_reset();
        tick();
        chk("mid_state_wait", 32'(dut.state), 32'(FETCH_WAIT));
        reset = 1'b1;
        #1;
        chk("mid_rst_state", 32'(dut.state), 32'(FETCH_IDLE));
        chk("mid_rst_fetch_pc", 32'(dut.fetch_pc), 32'(RESET_PC));
        chk("mid_rst_rom_req", 32'(bus.rom_req), 0);
        tick();
        tick();
        bus.redirect_pc    = 10'(RESET_PC);
        bus.redirect_valid = 1'b1;
        reset = 1'b0;
        r0 = req_cnt;
        tick();
        tick();
        stray_data = 16'hDEAD;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        chk("late_resp_count", 32'(dut.u_fifo.count), 0);
        chk("late_resp_valid", 32'(bus.instr_valid), 0);
        tick();
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b1;
        repeat (6) tick();
        chk("post_rst_reqs", 32'(req_cnt - r0), 2);
        chk("post_rst_pops", 32'(pop_log.size()), 1);
        chk("post_rst_first_pc", 32'(pop_log[0]), 32'(RESET_PC));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
